// File: rtl/miim_master.sv
// rtl/miim_master.sv - MDIO/MII clause-22 management master
//
// Serialises one clause-22 management frame per accepted request on MDC/MDIO.
// Optional build macro: MIIM_TA_CHECK_EN adds rd_err, which flags a read
// whose second turnaround bit was not driven low by the PHY.
//
// Ports:
//   clk, rstn      system clock, asynchronous active-low reset
//   miim_phyad     PHY address (latched on an accepted strobe)
//   miim_regad     register address (latched on an accepted strobe)
//   miim_wrdata    write data (latched on an accepted strobe)
//   miim_wren      single-cycle write request (wins over miim_rden)
//   miim_rden      single-cycle read request
//   busy           frame in progress
//   miim_rddata    last read data, held until the next read completes
//   miim_rdvalid   one-cycle pulse while miim_rddata holds fresh read data
//   mdc            management clock
//   mdio_o         MDIO output value
//   mdio_oe        MDIO output enable (1 = drive)
//   mdio_i         MDIO pin value
//   rd_err         (MIIM_TA_CHECK_EN only) read turnaround not acknowledged
module miim_master #(
  parameter int CLK_DIV      = 20,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  miim_phyad,
  input  logic [4:0]  miim_regad,
  input  logic [15:0] miim_wrdata,
  input  logic        miim_wren,
  input  logic        miim_rden,
  output logic        busy,
  output logic [15:0] miim_rddata,
  output logic        miim_rdvalid,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
`ifdef MIIM_TA_CHECK_EN
  ,
  output logic        rd_err
`endif
);

  localparam int BW = $clog2(2 * CLK_DIV);
  localparam logic [BW-1:0] BCNT_MID  = BW'(CLK_DIV);
  localparam logic [BW-1:0] BCNT_LAST = BW'(2 * CLK_DIV - 1);
  localparam logic [5:0]    PRE_LAST  = 6'(PREAMBLE_LEN - 1);

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} state_t;

  state_t        state, next_state;
  logic [BW-1:0] bcnt;
  logic [5:0]    bidx;
  logic [5:0]    last_idx;
  logic          op_rd;
  logic [4:0]    phyad_q;
  logic [4:0]    regad_q;
  logic [15:0]   wrdata_q;
  logic [15:0]   shreg;
  logic [13:0]   hdr;
  logic          accept;
  logic          bit_end;
  logic          field_end;

  assign accept    = (state == IDLE) && (miim_wren || miim_rden);
  assign bit_end   = (bcnt == BCNT_LAST);
  assign field_end = bit_end && (bidx == last_idx);
  assign hdr       = {2'b01, (op_rd ? 2'b10 : 2'b01), phyad_q, regad_q};

  always_comb begin
    last_idx = 6'd0;
    case (state)
      PRE:     last_idx = PRE_LAST;
      HDR:     last_idx = 6'd13;
      TA:      last_idx = 6'd1;
      DATA:    last_idx = 6'd15;
      default: last_idx = 6'd0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept)    next_state = PRE;
      PRE:     if (field_end) next_state = HDR;
      HDR:     if (field_end) next_state = TA;
      TA:      if (field_end) next_state = DATA;
      DATA:    if (field_end) next_state = DONE;
      DONE:                   next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  // Request latch, bit timer, bit index and read capture
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_rd       <= 1'b0;
      phyad_q     <= 5'd0;
      regad_q     <= 5'd0;
      wrdata_q    <= 16'd0;
      bcnt        <= '0;
      bidx        <= 6'd0;
      shreg       <= 16'd0;
      miim_rddata <= 16'd0;
`ifdef MIIM_TA_CHECK_EN
      rd_err      <= 1'b0;
`endif
    end else begin
      if (accept) begin
        // A simultaneous write and read request resolves to the write.
        op_rd    <= ~miim_wren;
        phyad_q  <= miim_phyad;
        regad_q  <= miim_regad;
        wrdata_q <= miim_wrdata;
`ifdef MIIM_TA_CHECK_EN
        rd_err   <= 1'b0;
`endif
      end

      if (state == IDLE || state == DONE) begin
        bcnt <= '0;
        bidx <= 6'd0;
      end else begin
        bcnt <= bit_end ? '0 : bcnt + BW'(1);
        if (bit_end) bidx <= (bidx == last_idx) ? 6'd0 : bidx + 6'd1;
      end

      // Sample on the MDC rising edge while the PHY drives the data field.
      if (state == DATA && op_rd && bcnt == BCNT_MID)
        shreg <= {shreg[14:0], mdio_i};

      // The last sample is already in shreg by the final clk of the field,
      // so the result is visible during DONE alongside miim_rdvalid.
      if (state == DATA && op_rd && field_end)
        miim_rddata <= shreg;

`ifdef MIIM_TA_CHECK_EN
      // A responding PHY pulls MDIO low during the second turnaround bit.
      if (state == TA && op_rd && bidx == 6'd1 && bcnt == BCNT_MID && mdio_i != 1'b0)
        rd_err <= 1'b1;
`endif
    end
  end

  // Output logic; MDIO values only change when bidx advances, i.e. at bcnt==0.
  always_comb begin
    busy         = (state != IDLE);
    mdc          = 1'b0;
    mdio_o       = 1'b1;
    mdio_oe      = 1'b0;
    miim_rdvalid = 1'b0;
    case (state)
      PRE: begin
        mdc     = (bcnt >= BCNT_MID);
        mdio_oe = 1'b1;
      end
      HDR: begin
        mdc     = (bcnt >= BCNT_MID);
        mdio_oe = 1'b1;
        mdio_o  = hdr[4'd13 - bidx[3:0]];
      end
      TA: begin
        mdc = (bcnt >= BCNT_MID);
        if (!op_rd) begin
          mdio_oe = 1'b1;
          mdio_o  = (bidx == 6'd0);
        end
      end
      DATA: begin
        mdc = (bcnt >= BCNT_MID);
        if (!op_rd) begin
          mdio_oe = 1'b1;
          mdio_o  = wrdata_q[4'd15 - bidx[3:0]];
        end
      end
      DONE: miim_rdvalid = op_rd;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_miim_master.sv
// tb/tb_miim_master.sv - self-checking bench for miim_master with a behavioural PHY
module tb_miim_master;

  localparam int CLK_DIV      = 2;
  localparam int PREAMBLE_LEN = 32;
  localparam int FRAME_BITS   = PREAMBLE_LEN + 32;
  localparam int BUSY_W       = FRAME_BITS * 2 * CLK_DIV + 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [4:0]  miim_phyad = '0;
  logic [4:0]  miim_regad = '0;
  logic [15:0] miim_wrdata = '0;
  logic        miim_wren = 1'b0;
  logic        miim_rden = 1'b0;
  logic        busy;
  logic [15:0] miim_rddata;
  logic        miim_rdvalid;
  logic        mdc;
  logic        mdio_o;
  logic        mdio_oe;
  logic        mdio_i = 1'b1;
`ifdef MIIM_TA_CHECK_EN
  logic        rd_err;
`endif

  int passed = 0;
  int total  = 0;

  miim_master #(.CLK_DIV(CLK_DIV), .PREAMBLE_LEN(PREAMBLE_LEN)) dut (
    .clk(clk),
    .rstn(rstn),
    .miim_phyad(miim_phyad),
    .miim_regad(miim_regad),
    .miim_wrdata(miim_wrdata),
    .miim_wren(miim_wren),
    .miim_rden(miim_rden),
    .busy(busy),
    .miim_rddata(miim_rddata),
    .miim_rdvalid(miim_rdvalid),
    .mdc(mdc),
    .mdio_o(mdio_o),
    .mdio_oe(mdio_oe),
    .mdio_i(mdio_i)
`ifdef MIIM_TA_CHECK_EN
    ,
    .rd_err(rd_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // PHY model: value it presents for frame bit n (pull-up gives 1 when idle).
  function automatic logic phy_bit(input int n, input logic [15:0] d, input bit present);
    if (!present) return 1'b1;
    if (n == FRAME_BITS - 17) return 1'b0;
    if (n >= FRAME_BITS - 16 && n < FRAME_BITS) return d[FRAME_BITS - 1 - n];
    return 1'b1;
  endfunction

  // Issues one request (caller is #1 after a posedge) and checks the whole frame.
  task automatic run_frame(input string tag, input bit wr, input bit rd,
                           input logic [4:0] pa, input logic [4:0] ra,
                           input logic [15:0] wd, input logic [15:0] pd,
                           input bit present, input int inject);
    logic [63:0] cap_o, cap_oe, exp_o, exp_oe;
    logic [15:0] rd_got;
    bit          is_rd;
    logic        prev;
    int n, cyc, bw, last_rise, per_err, rdv_cnt, rdv_cyc;

    is_rd  = rd && !wr;
    exp_o  = {32'hFFFF_FFFF, 2'b01, (is_rd ? 2'b10 : 2'b01), pa, ra,
              (is_rd ? 2'b11 : 2'b10), (is_rd ? 16'hFFFF : wd)};
    exp_oe = is_rd ? {{46{1'b1}}, 18'd0} : {64{1'b1}};

    miim_phyad = pa; miim_regad = ra; miim_wrdata = wd;
    miim_wren = wr; miim_rden = rd;
    @(posedge clk); #1;
    miim_wren = 1'b0; miim_rden = 1'b0;
    check({tag, "_busy_rise"}, 64'(busy), 64'd1);

    cap_o = '1; cap_oe = '0; rd_got = '0;
    n = 0; cyc = 0; bw = 0; last_rise = -1; per_err = 0; rdv_cnt = 0; rdv_cyc = -1;
    prev = mdc;
    while (busy && cyc < 2000) begin
      bw++;
      if (mdc && !prev) begin
        if (n < 64) begin
          cap_o[63 - n]  = mdio_o;
          cap_oe[63 - n] = mdio_oe;
        end
        if (last_rise >= 0 && cyc - last_rise != 2 * CLK_DIV) per_err++;
        last_rise = cyc;
        n++;
      end
      if (!mdc && prev) mdio_i = phy_bit(n, pd, present);
      if (miim_rdvalid) begin
        rdv_cnt++;
        rd_got  = miim_rddata;
        rdv_cyc = cyc;
      end
      if (cyc == inject) begin
        miim_wren = 1'b1; miim_regad = 5'd5; miim_wrdata = ~wd;
      end else if (cyc == inject + 1) begin
        miim_wren = 1'b0; miim_regad = ra; miim_wrdata = wd;
      end
      prev = mdc;
      @(posedge clk); #1;
      cyc++;
    end
    mdio_i = 1'b1;

    check({tag, "_busy_width"}, 64'(bw), 64'(BUSY_W));
    check({tag, "_mdc_rises"}, 64'(n), 64'(FRAME_BITS));
    check({tag, "_mdc_period"}, 64'(per_err), 64'd0);
    check({tag, "_oe_bits"}, cap_oe, exp_oe);
    check({tag, "_mdio_bits"}, cap_o & exp_oe, exp_o & exp_oe);
    check({tag, "_rdvalid_cnt"}, 64'(rdv_cnt), 64'(is_rd));
    if (is_rd) begin
      check({tag, "_rddata"}, 64'(rd_got), 64'(present ? pd : 16'hFFFF));
      check({tag, "_rdvalid_last_busy"}, 64'(rdv_cyc), 64'(bw - 1));
    end
    check({tag, "_idle_after"}, {62'd0, mdc, mdio_oe}, 64'd0);
  endtask

  initial begin
    logic [4:0]  pa, ra;
    logic [15:0] wd, pd;
    bit          op;
    int          n, cyc, rdv;
    logic        prev;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mdc", 64'(mdc), 64'd0);
    check("rst_oe", 64'(mdio_oe), 64'd0);
    check("rst_mdio_o", 64'(mdio_o), 64'd1);
    check("rst_rddata", 64'(miim_rddata), 64'd0);
    check("rst_rdvalid", 64'(miim_rdvalid), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Directed write, read, collision with an ignored mid-frame write
    run_frame("wr", 1'b1, 1'b0, 5'd0, 5'd0, 16'h0044, 16'h0000, 1'b1, -1);
    run_frame("rd", 1'b0, 1'b1, 5'd0, 5'd2, 16'h0000, 16'h0283, 1'b1, -1);
`ifdef MIIM_TA_CHECK_EN
    check("rd_err_good_phy", 64'(rd_err), 64'd0);
`endif
    run_frame("coll", 1'b1, 1'b1, 5'd3, 5'd9, 16'hA5C3, 16'h0000, 1'b1, 100);
    check("rddata_held", 64'(miim_rddata), 64'h0283);

    // Abort a read in the DATA field
    miim_phyad = 5'd1; miim_regad = 5'd4; miim_rden = 1'b1;
    @(posedge clk); #1;
    miim_rden = 1'b0;
    n = 0; cyc = 0; prev = mdc;
    while (n < FRAME_BITS - 8 && cyc < 2000) begin
      if (mdc && !prev) n++;
      prev = mdc;
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_reached_data", 64'(n), 64'(FRAME_BITS - 8));
    rstn = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_mdc", 64'(mdc), 64'd0);
    check("abort_oe", 64'(mdio_oe), 64'd0);
    check("abort_mdio_o", 64'(mdio_o), 64'd1);
    check("abort_rddata", 64'(miim_rddata), 64'd0);
    rdv = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (miim_rdvalid) rdv++;
    end
    rstn = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (miim_rdvalid) rdv++;
    end
    check("abort_no_rdvalid", 64'(rdv), 64'd0);
    run_frame("post_abort_rd", 1'b0, 1'b1, 5'd1, 5'd4, 16'h0000, 16'h5A0F, 1'b1, -1);

    // Randomized frames
    for (int i = 0; i < 4; i++) begin
      op = 1'($urandom_range(0, 1));
      pa = 5'($urandom);
      ra = 5'($urandom);
      wd = 16'($urandom);
      pd = 16'($urandom);
      run_frame($sformatf("rnd%0d", i), op, !op, pa, ra, wd, pd, 1'b1, -1);
    end

`ifdef MIIM_TA_CHECK_EN
    // Absent PHY: turnaround not pulled low
    run_frame("nophy_rd", 1'b0, 1'b1, 5'd7, 5'd1, 16'h0000, 16'hFFFF, 1'b0, -1);
    check("rd_err_set", 64'(rd_err), 64'd1);
    miim_wren = 1'b1;
    @(posedge clk); #1;
    miim_wren = 1'b0;
    check("rd_err_cleared", 64'(rd_err), 64'd0);
    cyc = 0;
    while (busy && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rd_err_clear_frame_done", 64'(busy), 64'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
